tlb_op_ctrl: RTL and testbench

- Sequences the MIPS TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR issued from the MEM stage.
- Arbitrates TLB search port 1 between ordinary data translation and TLBP.
- Drives the TLB write and read ports, generates the CP0 Random index, and stalls the pipeline until each op commits its result to CP0.
- Sits between MEM-stage decode, CP0 and the TLB/MMU block.

---
 rtl/tlb_pkg.sv | 29 ++
 rtl/tlb_random_ctr.sv | 48 ++++
 rtl/tlb_op_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared types and constants for the TLB maintenance-op controller.
//   TLBNUM       : number of TLB entries
//   IDX_W        : TLB index width ($clog2(TLBNUM))
//   TLBOpType    : MEM-stage TLB op encoding (TLBP/TLBR/TLBWI/TLBWR)
//   TLBCtrlState : sequencer states
// -----------------------------------------------------------------------------
package tlb_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = $clog2(TLBNUM);

  typedef enum logic [1:0] {
    TLBP  = 2'b00,
    TLBR  = 2'b01,
    TLBWI = 2'b10,
    TLBWR = 2'b11
  } TLBOpType;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SRCH   = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_COMMIT = 3'd4
  } TLBCtrlState;

endpackage

// File: rtl/tlb_random_ctr.sv
// -----------------------------------------------------------------------------
// tlb_random_ctr
// CP0 Random register. Counts down once per cycle from TLBNUM-1 to cp0_wired
// and wraps back to TLBNUM-1, so TLBWR never replaces a wired entry.
// Only built when TLB_RANDOM_EN is defined.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (Random -> TLBNUM-1)
//   cp0_wired     : CP0 Wired value (lower bound of Random)
//   cp0_wired_we  : Wired being written; reloads Random to TLBNUM-1
//   random        : current Random value
// -----------------------------------------------------------------------------
module tlb_random_ctr #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLBNUM - 1);

  logic [IDX_W-1:0] r_random;
  logic [IDX_W-1:0] w_random_nxt;

  // Reload when Wired is being written, when Wired leaves no random range,
  // or when the bottom of the range has been reached. Using <= also pulls
  // Random back into range if Wired ever moves above it.
  always_comb begin
    w_random_nxt = r_random - IDX_W'(1);
    if (cp0_wired_we || (cp0_wired >= MAX_IDX) || (r_random <= cp0_wired)) begin
      w_random_nxt = MAX_IDX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_random <= MAX_IDX;
    end else begin
      r_random <= w_random_nxt;
    end
  end

  assign random = r_random;

endmodule

// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
// Sequences TLBP / TLBR / TLBWI / TLBWR from the MEM stage: borrows TLB search
// port 1 for TLBP, drives the TLB read/write ports, writes results back to CP0
// and stalls IF..MEM until the op reaches COMMIT (2 cycles accept -> op_done).
// Optional feature macro: TLB_RANDOM_EN (CP0 Random counter; TLBWR uses the
// Random value sampled at accept). Without it Random is tied to TLBNUM-1 and
// TLBWR behaves as TLBWI.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   op_valid, op_type, mem_flush   : MEM-stage op request and flush
//   stall_req, op_done             : pipeline hold, completion pulse
//   s1_sel, s1_found, s1_index     : search port 1 select and result
//   tlb_we, tlb_w_index            : TLB write port control
//   tlb_r_index                    : TLB read port index
//   cp0_index, cp0_wired(_we)      : CP0 Index / Wired inputs
//   cp0_probe_we/_p/_index         : Index register update from TLBP
//   cp0_read_we                    : EntryHi/Lo load from TLBR
//   random                         : CP0 Random value
// -----------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic             mem_flush,
  output logic             stall_req,
  output logic             op_done,
  output logic             s1_sel,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic [IDX_W-1:0] tlb_r_index,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  output logic             cp0_probe_we,
  output logic             cp0_probe_p,
  output logic [IDX_W-1:0] cp0_probe_index,
  output logic             cp0_read_we,
  output logic [IDX_W-1:0] random
);

  import tlb_pkg::*;

  TLBCtrlState      r_state;
  TLBCtrlState      w_state_nxt;
  TLBOpType         r_op;
  logic [IDX_W-1:0] r_w_idx;
  logic             r_found;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic [IDX_W-1:0] w_w_idx_sel;
  logic [IDX_W-1:0] w_random;

`ifdef TLB_RANDOM_EN
  tlb_random_ctr #(
    .TLBNUM (TLBNUM),
    .IDX_W  (IDX_W)
  ) u_random (
    .clk          (clk),
    .rst          (rst),
    .cp0_wired    (cp0_wired),
    .cp0_wired_we (cp0_wired_we),
    .random       (w_random)
  );

  assign w_w_idx_sel = (op_type == TLBWR) ? w_random : cp0_index;
`else
  // No Random counter: Wired inputs have no effect.
  logic w_unused_wired;
  assign w_unused_wired = ^{cp0_wired, cp0_wired_we};

  assign w_random    = IDX_W'(TLBNUM - 1);
  assign w_w_idx_sel = cp0_index;
`endif

  assign random   = w_random;
  assign w_accept = (r_state == ST_IDLE) && op_valid && !mem_flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Op context: data only, qualified by state so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= TLBOpType'(op_type);
      r_w_idx <= w_w_idx_sel;
    end
    if (r_state == ST_SRCH) begin
      r_found <= s1_found;
      r_idx   <= s1_index;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (TLBOpType'(op_type))
            TLBP:    w_state_nxt = ST_SRCH;
            TLBR:    w_state_nxt = ST_RD;
            default: w_state_nxt = ST_WR;
          endcase
        end
      end
      ST_SRCH, ST_RD, ST_WR: begin
        // A flush abandons the op before anything becomes architectural.
        w_state_nxt = mem_flush ? ST_IDLE : ST_COMMIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall_req       = 1'b0;
    op_done         = 1'b0;
    s1_sel          = 1'b0;
    tlb_we          = 1'b0;
    tlb_w_index     = '0;
    tlb_r_index     = '0;
    cp0_probe_we    = 1'b0;
    cp0_probe_p     = 1'b0;
    cp0_probe_index = '0;
    cp0_read_we     = 1'b0;
    case (r_state)
      ST_IDLE: stall_req = w_accept;
      ST_SRCH: begin
        stall_req = 1'b1;
        s1_sel    = 1'b1;
      end
      ST_RD: begin
        stall_req   = 1'b1;
        tlb_r_index = cp0_index;
      end
      ST_WR: begin
        stall_req   = 1'b1;
        tlb_we      = !mem_flush;
        tlb_w_index = r_w_idx;
      end
      ST_COMMIT: begin
        // Stall drops here so the op leaves MEM as its CP0 result lands.
        op_done = !mem_flush;
        if (r_op == TLBP) begin
          cp0_probe_we    = !mem_flush;
          cp0_probe_p     = !r_found;
          cp0_probe_index = r_found ? r_idx : '0;
        end
        if (r_op == TLBR) begin
          cp0_read_we = !mem_flush;
          tlb_r_index = cp0_index;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_ctrl
// Directed testbench for tlb_op_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are observed 1 time unit later, mid-cycle.
// -----------------------------------------------------------------------------
module tb_tlb_op_ctrl;

  localparam int IDX_W = 4;

`ifdef TLB_RANDOM_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic [1:0]       op_type;
  logic             mem_flush;
  logic             stall_req;
  logic             op_done;
  logic             s1_sel;
  logic             s1_found;
  logic [IDX_W-1:0] s1_index;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_w_index;
  logic [IDX_W-1:0] tlb_r_index;
  logic [IDX_W-1:0] cp0_index;
  logic [IDX_W-1:0] cp0_wired;
  logic             cp0_wired_we;
  logic             cp0_probe_we;
  logic             cp0_probe_p;
  logic [IDX_W-1:0] cp0_probe_index;
  logic             cp0_read_we;
  logic [IDX_W-1:0] random;

  int n_cmp = 0;
  int n_err = 0;

  tlb_op_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op_type         (op_type),
    .mem_flush       (mem_flush),
    .stall_req       (stall_req),
    .op_done         (op_done),
    .s1_sel          (s1_sel),
    .s1_found        (s1_found),
    .s1_index        (s1_index),
    .tlb_we          (tlb_we),
    .tlb_w_index     (tlb_w_index),
    .tlb_r_index     (tlb_r_index),
    .cp0_index       (cp0_index),
    .cp0_wired       (cp0_wired),
    .cp0_wired_we    (cp0_wired_we),
    .cp0_probe_we    (cp0_probe_we),
    .cp0_probe_p     (cp0_probe_p),
    .cp0_probe_index (cp0_probe_index),
    .cp0_read_we     (cp0_read_we),
    .random          (random)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before observing.
  task automatic settle();
    #1;
  endtask

  logic [IDX_W-1:0] rnd_tbl [4];
  logic [IDX_W-1:0] wr_idx_exp;

  initial begin
    rst          = 1'b1;
    op_valid     = 1'b0;
    op_type      = 2'b00;
    mem_flush    = 1'b0;
    s1_found     = 1'b0;
    s1_index     = '0;
    cp0_index    = '0;
    cp0_wired    = 4'd13;
    cp0_wired_we = 1'b0;

    if (RND_EN) begin
      rnd_tbl[0] = 4'd14; rnd_tbl[1] = 4'd13; rnd_tbl[2] = 4'd15; rnd_tbl[3] = 4'd14;
      wr_idx_exp = 4'd14;
    end else begin
      rnd_tbl[0] = 4'd15; rnd_tbl[1] = 4'd15; rnd_tbl[2] = 4'd15; rnd_tbl[3] = 4'd15;
      wr_idx_exp = 4'd3;
    end

    // ---- reset state ----
    next_cycle();
    next_cycle();
    settle();
    chk("rst_stall", {7'd0, stall_req}, 8'd0);
    chk("rst_done", {7'd0, op_done}, 8'd0);
    chk("rst_s1sel", {7'd0, s1_sel}, 8'd0);
    chk("rst_we", {7'd0, tlb_we}, 8'd0);
    chk("rst_probe_we", {7'd0, cp0_probe_we}, 8'd0);
    chk("rst_read_we", {7'd0, cp0_read_we}, 8'd0);
    chk("rst_random", {4'd0, random}, 8'd15);
    rst = 1'b0;

    // ---- Random sequence with Wired = 13 ----
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      chk($sformatf("rnd_seq%0d", i), {4'd0, random}, {4'd0, rnd_tbl[i]});
    end
    // Wired write while Random = 14 forces a reload to 15.
    cp0_wired_we = 1'b1;
    next_cycle();
    cp0_wired_we = 1'b0;
    settle();
    chk("rnd_wired_we", {4'd0, random}, 8'd15);
    next_cycle();
    settle();
    chk("rnd_after_we", {4'd0, random}, RND_EN ? 8'd14 : 8'd15);

    // ---- TLBWR accepted while Random = 14 ----
    op_valid = 1'b1; op_type = 2'b11; cp0_index = 4'd3;
    settle();
    chk("wr_acc_stall", {7'd0, stall_req}, 8'd1);
    next_cycle();
    op_valid = 1'b0;
    settle();
    chk("wr_we", {7'd0, tlb_we}, 8'd1);
    chk("wr_widx", {4'd0, tlb_w_index}, {4'd0, wr_idx_exp});
    next_cycle();
    settle();
    chk("wr_done", {7'd0, op_done}, 8'd1);
    chk("wr_we_commit", {7'd0, tlb_we}, 8'd0);
    next_cycle();
    settle();
    chk("wr_done_idle", {7'd0, op_done}, 8'd0);

    // ---- TLBP hit on entry 5 ----
    op_valid = 1'b1; op_type = 2'b00; s1_found = 1'b1; s1_index = 4'd5;
    settle();
    chk("ph_c0_stall", {7'd0, stall_req}, 8'd1);
    chk("ph_c0_s1sel", {7'd0, s1_sel}, 8'd0);
    next_cycle();
    op_valid = 1'b0;
    settle();
    chk("ph_c1_s1sel", {7'd0, s1_sel}, 8'd1);
    chk("ph_c1_stall", {7'd0, stall_req}, 8'd1);
    chk("ph_c1_done", {7'd0, op_done}, 8'd0);
    next_cycle();
    s1_found = 1'b0; s1_index = 4'd0;
    settle();
    chk("ph_c2_pwe", {7'd0, cp0_probe_we}, 8'd1);
    chk("ph_c2_p", {7'd0, cp0_probe_p}, 8'd0);
    chk("ph_c2_idx", {4'd0, cp0_probe_index}, 8'd5);
    chk("ph_c2_done", {7'd0, op_done}, 8'd1);
    chk("ph_c2_stall", {7'd0, stall_req}, 8'd0);
    chk("ph_c2_s1sel", {7'd0, s1_sel}, 8'd0);

    // ---- TLBP miss, accepted back-to-back ----
    next_cycle();
    op_valid = 1'b1; op_type = 2'b00; s1_found = 1'b0; s1_index = 4'd7;
    settle();
    chk("pm_c0_stall", {7'd0, stall_req}, 8'd1);
    next_cycle();
    op_valid = 1'b0;
    next_cycle();
    settle();
    chk("pm_c2_pwe", {7'd0, cp0_probe_we}, 8'd1);
    chk("pm_c2_p", {7'd0, cp0_probe_p}, 8'd1);
    chk("pm_c2_idx", {4'd0, cp0_probe_index}, 8'd0);

    // ---- TLBWI index 9 ----
    next_cycle();
    op_valid = 1'b1; op_type = 2'b10; cp0_index = 4'd9;
    settle();
    chk("wi_c0_we", {7'd0, tlb_we}, 8'd0);
    next_cycle();
    op_valid = 1'b0;
    settle();
    chk("wi_c1_we", {7'd0, tlb_we}, 8'd1);
    chk("wi_c1_widx", {4'd0, tlb_w_index}, 8'd9);
    chk("wi_c1_done", {7'd0, op_done}, 8'd0);
    next_cycle();
    settle();
    chk("wi_c2_we", {7'd0, tlb_we}, 8'd0);
    chk("wi_c2_done", {7'd0, op_done}, 8'd1);

    // ---- TLBR index 9 ----
    next_cycle();
    op_valid = 1'b1; op_type = 2'b01;
    settle();
    chk("rd_c0_stall", {7'd0, stall_req}, 8'd1);
    next_cycle();
    op_valid = 1'b0;
    settle();
    chk("rd_c1_ridx", {4'd0, tlb_r_index}, 8'd9);
    chk("rd_c1_rwe", {7'd0, cp0_read_we}, 8'd0);
    next_cycle();
    settle();
    chk("rd_c2_rwe", {7'd0, cp0_read_we}, 8'd1);
    chk("rd_c2_ridx", {4'd0, tlb_r_index}, 8'd9);
    chk("rd_c2_done", {7'd0, op_done}, 8'd1);

    // ---- mem_flush in WR ----
    next_cycle();
    op_valid = 1'b1; op_type = 2'b10; cp0_index = 4'd2;
    next_cycle();
    op_valid = 1'b0; mem_flush = 1'b1;
    settle();
    chk("fw_c1_we", {7'd0, tlb_we}, 8'd0);
    chk("fw_c1_done", {7'd0, op_done}, 8'd0);
    next_cycle();
    mem_flush = 1'b0;
    // A new request stalls combinationally only when the FSM is in IDLE.
    op_valid = 1'b1; op_type = 2'b00; s1_found = 1'b1; s1_index = 4'd4;
    settle();
    chk("fw_c2_done", {7'd0, op_done}, 8'd0);
    chk("fw_c2_we", {7'd0, tlb_we}, 8'd0);
    chk("fw_c2_idle", {7'd0, stall_req}, 8'd1);

    // ---- mem_flush in COMMIT of TLBP ----
    next_cycle();
    op_valid = 1'b0;
    settle();
    chk("fc_c1_s1sel", {7'd0, s1_sel}, 8'd1);
    next_cycle();
    mem_flush = 1'b1;
    settle();
    chk("fc_c2_pwe", {7'd0, cp0_probe_we}, 8'd0);
    chk("fc_c2_done", {7'd0, op_done}, 8'd0);
    next_cycle();
    mem_flush = 1'b0;
    settle();
    chk("fc_c3_pwe", {7'd0, cp0_probe_we}, 8'd0);

    // ---- rst in SRCH ----
    op_valid = 1'b1; op_type = 2'b00;
    next_cycle();
    op_valid = 1'b0;
    settle();
    chk("rs_c1_s1sel", {7'd0, s1_sel}, 8'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rs_c2_stall", {7'd0, stall_req}, 8'd0);
    chk("rs_c2_s1sel", {7'd0, s1_sel}, 8'd0);
    chk("rs_c2_pwe", {7'd0, cp0_probe_we}, 8'd0);
    chk("rs_c2_done", {7'd0, op_done}, 8'd0);
    chk("rs_c2_random", {4'd0, random}, 8'd15);
    next_cycle();
    settle();
    chk("rs_c3_done", {7'd0, op_done}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
